// File: rtl/clock_time_controller.sv
`default_nettype none
// ============================================================================
// Module      : clock_time_controller
// Description : HH:MM:SS run/set sequencer for a 24-hour clock, with a blink
//               qualifier for the field being set and an optional hourly chime
//               (enabled by defining CHIME_EN).
// Revision    : 1.0 - initial release
// ============================================================================
module clock_time_controller #(
    parameter int unsigned BLINK_CYCLES = 12500000,
    parameter int unsigned CHIME_SECS   = 3
) (
    input  logic       CLK_50M,
    input  logic       CLR,
    input  logic       TICK_1HZ,
    input  logic       BTN_MODE,
    input  logic       BTN_INC,
    output logic [4:0] HOUR,
    output logic [5:0] MIN,
    output logic [5:0] SEC,
    output logic [1:0] MODE,
    output logic       BLINK,
    output logic       CHIME
);

    localparam int unsigned c_CNT_W = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
    localparam logic [c_CNT_W-1:0] c_BLINK_MAX = c_CNT_W'(BLINK_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_SET_HOUR = 2'd1,
        ST_SET_MIN  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [4:0]         hour_q, hour_d;
    logic [5:0]         min_q, min_d;
    logic [5:0]         sec_q, sec_d;
    logic               blink_q, blink_d;
    logic [c_CNT_W-1:0] cnt_q, cnt_d;
    logic               w_cnt_done;

    assign w_cnt_done = (cnt_q == c_BLINK_MAX);

    always_ff @(posedge CLK_50M) begin
        if (CLR) begin
            state_q <= ST_RUN;
            hour_q  <= 5'd0;
            min_q   <= 6'd0;
            sec_q   <= 6'd0;
            blink_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            hour_q  <= hour_d;
            min_q   <= min_d;
            sec_q   <= sec_d;
            blink_q <= blink_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        hour_d  = hour_q;
        min_d   = min_q;
        sec_d   = sec_q;
        blink_d = blink_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_RUN: begin
                blink_d = 1'b0;
                cnt_d   = '0;
                if (TICK_1HZ) begin
                    if (sec_q == 6'd59) begin
                        sec_d = 6'd0;
                        if (min_q == 6'd59) begin
                            min_d  = 6'd0;
                            hour_d = (hour_q == 5'd23) ? 5'd0 : hour_q + 5'd1;
                        end else begin
                            min_d = min_q + 6'd1;
                        end
                    end else begin
                        sec_d = sec_q + 6'd1;
                    end
                end
                // The tick's MIN/HOUR carries survive; only SEC is cleared.
                if (BTN_MODE) begin
                    state_d = ST_SET_HOUR;
                    sec_d   = 6'd0;
                    blink_d = 1'b1;
                end
            end
            ST_SET_HOUR: begin
                if (BTN_MODE) begin
                    state_d = ST_SET_MIN;
                    blink_d = 1'b1;
                    cnt_d   = '0;
                end else if (BTN_INC) begin
                    hour_d  = (hour_q == 5'd23) ? 5'd0 : hour_q + 5'd1;
                    blink_d = 1'b1;
                    cnt_d   = '0;
                end else if (w_cnt_done) begin
                    blink_d = ~blink_q;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + c_CNT_W'(1);
                end
            end
            ST_SET_MIN: begin
                if (BTN_MODE) begin
                    state_d = ST_RUN;
                    blink_d = 1'b0;
                    cnt_d   = '0;
                end else if (BTN_INC) begin
                    min_d   = (min_q == 6'd59) ? 6'd0 : min_q + 6'd1;
                    blink_d = 1'b1;
                    cnt_d   = '0;
                end else if (w_cnt_done) begin
                    blink_d = ~blink_q;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + c_CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_RUN;
                blink_d = 1'b0;
                cnt_d   = '0;
            end
        endcase
    end

    assign HOUR  = hour_q;
    assign MIN   = min_q;
    assign SEC   = sec_q;
    assign MODE  = state_q;
    assign BLINK = blink_q;

`ifdef CHIME_EN
    localparam logic [5:0] c_CHIME_SECS = 6'(CHIME_SECS);

    logic armed_q, armed_d;
    logic chime_q, chime_d;
    logic w_min_wrap;

    // Only a running tick that rolls the minute over arms the chime.
    assign w_min_wrap = (state_q == ST_RUN) && TICK_1HZ &&
                        (sec_q == 6'd59) && (min_q == 6'd59);

    always_comb begin
        armed_d = armed_q;
        if (BTN_MODE) begin
            armed_d = 1'b0;
        end else if (w_min_wrap) begin
            armed_d = 1'b1;
        end else if (sec_d == c_CHIME_SECS) begin
            armed_d = 1'b0;
        end
        chime_d = armed_d && (sec_d < c_CHIME_SECS);
    end

    always_ff @(posedge CLK_50M) begin
        if (CLR) begin
            armed_q <= 1'b0;
            chime_q <= 1'b0;
        end else begin
            armed_q <= armed_d;
            chime_q <= chime_d;
        end
    end

    assign CHIME = chime_q;
`else
    assign CHIME = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_clock_time_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_clock_time_controller
// Description : Directed self-checking bench for clock_time_controller.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_clock_time_controller;

    logic       clk;
    logic       rst;
    logic       tick;
    logic       btn_mode;
    logic       btn_inc;
    logic [4:0] hour;
    logic [5:0] min;
    logic [5:0] sec;
    logic [1:0] mode;
    logic       blink;
    logic       chime;

    int checks = 0;
    int errors = 0;

    clock_time_controller #(
        .BLINK_CYCLES(4),
        .CHIME_SECS  (3)
    ) u_dut (
        .CLK_50M (clk),
        .CLR     (rst),
        .TICK_1HZ(tick),
        .BTN_MODE(btn_mode),
        .BTN_INC (btn_inc),
        .HOUR    (hour),
        .MIN     (min),
        .SEC     (sec),
        .MODE    (mode),
        .BLINK   (blink),
        .CHIME   (chime)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_time(input string tag, input int h, input int m, input int s, input int md);
        check_value({tag, ".hour"}, 32'(hour), 32'(h));
        check_value({tag, ".min"},  32'(min),  32'(m));
        check_value({tag, ".sec"},  32'(sec),  32'(s));
        check_value({tag, ".mode"}, 32'(mode), 32'(md));
    endtask

    task automatic pulse(input logic m, input logic i, input logic t);
        btn_mode = m;
        btn_inc  = i;
        tick     = t;
        @(posedge clk);
        #1;
        btn_mode = 1'b0;
        btn_inc  = 1'b0;
        tick     = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) pulse(1'b0, 1'b0, 1'b1);
    endtask

    task automatic incs(input int n);
        for (int k = 0; k < n; k++) pulse(1'b0, 1'b1, 1'b0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    logic exp_blink_a [8];
    logic exp_blink_b [4];

    initial begin
        exp_blink_a = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        exp_blink_b = '{1'b1, 1'b1, 1'b1, 1'b0};
        rst = 1'b1; tick = 1'b0; btn_mode = 1'b0; btn_inc = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_time("reset", 0, 0, 0, 0);
        check_value("reset.blink", 32'(blink), 32'd0);
        check_value("reset.chime", 32'(chime), 32'd0);
        rst = 1'b0;

        // 3661 seconds of running time
        ticks(3661);
        check_time("run3661", 1, 1, 1, 0);
        check_value("run3661.blink", 32'(blink), 32'd0);

        // Preload 23:59:59 then roll over
        pulse(1'b1, 1'b0, 1'b0);
        check_time("enter_sethour", 1, 1, 0, 1);
        incs(22);
        pulse(1'b1, 1'b0, 1'b0);
        incs(58);
        check_time("preset_min", 23, 59, 0, 2);
        pulse(1'b1, 1'b0, 1'b0);
        check_value("back_run.blink", 32'(blink), 32'd0);
        ticks(59);
        check_time("pre_roll", 23, 59, 59, 0);
        for (int s = 0; s <= 3; s++) begin
            ticks(1);
            check_time("roll", 0, 0, s, 0);
`ifdef CHIME_EN
            check_value("roll.chime", 32'(chime), (s < 3) ? 32'd1 : 32'd0);
`else
            check_value("roll.chime", 32'(chime), 32'd0);
`endif
        end

        // Enter SET_HOUR, 25 increments with ticks riding along
        pulse(1'b1, 1'b0, 1'b0);
        check_value("sethour.blink", 32'(blink), 32'd1);
        for (int k = 0; k < 25; k++) pulse(1'b0, 1'b1, 1'b1);
        check_time("inc25", 1, 0, 0, 1);
        check_value("inc25.blink", 32'(blink), 32'd1);

        // Blink pattern with BLINK_CYCLES=4
        for (int k = 0; k < 8; k++) begin
            pulse(1'b0, 1'b0, 1'b0);
            check_value($sformatf("blink_a%0d", k), 32'(blink), 32'(exp_blink_a[k]));
        end
        repeat (5) pulse(1'b0, 1'b0, 1'b0);
        check_value("blink_low", 32'(blink), 32'd0);
        pulse(1'b0, 1'b1, 1'b0);
        check_value("inc_force.blink", 32'(blink), 32'd1);
        check_value("inc_force.hour", 32'(hour), 32'd2);
        for (int k = 0; k < 4; k++) begin
            pulse(1'b0, 1'b0, 1'b0);
            check_value($sformatf("blink_b%0d", k), 32'(blink), 32'(exp_blink_b[k]));
        end

        // Mode beats increment
        incs(3);
        check_value("hour5", 32'(hour), 32'd5);
        pulse(1'b1, 1'b1, 1'b0);
        check_time("mode_inc", 5, 0, 0, 2);
        check_value("mode_inc.blink", 32'(blink), 32'd1);
        pulse(1'b1, 1'b0, 1'b0);
        check_value("run_again.mode", 32'(mode), 32'd0);
        check_value("run_again.blink", 32'(blink), 32'd0);

        // Mode together with a tick at 00:00:59
        do_reset();
        ticks(59);
        check_time("at59", 0, 0, 59, 0);
        pulse(1'b1, 1'b0, 1'b1);
        check_time("mode_tick", 0, 1, 0, 1);

        // Reset in SET_MIN at 12:34
        incs(12);
        pulse(1'b1, 1'b0, 1'b0);
        incs(33);
        check_time("set1234", 12, 34, 0, 2);
        do_reset();
        check_time("clr_setmin", 0, 0, 0, 0);
        check_value("clr_setmin.blink", 32'(blink), 32'd0);
        check_value("clr_setmin.chime", 32'(chime), 32'd0);
        ticks(1);
        check_time("after_clr", 0, 0, 1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
